// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back wins, long-latency results wait in a FIFO.
// Optional build macro WB_ARB_STATS_EN adds the 32-bit saturating conflict_count output.
`ifndef XLEN
`define XLEN 32
`endif

module wb_port_arbiter #(
   parameter int DEPTH    = 2,
   parameter int REG_BITS = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pipe_valid,
   input  logic [REG_BITS-1:0] pipe_rd,
   input  logic [`XLEN-1:0]    pipe_data,
   input  logic                lu_valid,
   input  logic [REG_BITS-1:0] lu_rd,
   input  logic [`XLEN-1:0]    lu_data,
   output logic                lu_ready,
   input  logic [REG_BITS-1:0] query_rs1,
   input  logic [REG_BITS-1:0] query_rs2,
   output logic                query_stall,
   input  logic                halt_req,
   output logic                halted,
   output logic                rf_we,
   output logic [REG_BITS-1:0] rf_rd,
   output logic [`XLEN-1:0]    rf_wdata
`ifdef WB_ARB_STATS_EN
   ,
   output logic [31:0]         conflict_count
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
   localparam logic [REG_BITS-1:0] RD_ZERO = {REG_BITS{1'b0}};

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic                run_s;

   logic [REG_BITS-1:0] rd_mem_r   [DEPTH];
   logic [`XLEN-1:0]    data_mem_r [DEPTH];
   logic [DEPTH-1:0]    live_r;
   logic [DEPTH-1:0]    live_nxt_s;
   logic [PW-1:0]       wr_ptr_r;
   logic [PW-1:0]       rd_ptr_r;
   logic [CW-1:0]       count_r;

   logic                pipe_wr_s;
   logic                fifo_empty_s;
   logic                lu_xfer_s;
   logic                push_s;
   logic                pop_s;

   assign pipe_wr_s    = pipe_valid && (pipe_rd != RD_ZERO);
   assign fifo_empty_s = (count_r == {CW{1'b0}});
   assign lu_ready     = run_s && (count_r < DEPTH_C);
   assign lu_xfer_s    = lu_valid && lu_ready;
   assign push_s       = lu_xfer_s && (lu_rd != RD_ZERO);
   assign pop_s        = !fifo_empty_s && !pipe_wr_s;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (halt_req) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty_s && !pipe_wr_s) begin
               state_nxt_s = ST_HALTED;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_HALTED: state_nxt_s = ST_HALTED;
         default:   state_nxt_s = ST_RUN;
      endcase
   end

   // FSM output decode
   always_comb begin
      run_s  = 1'b0;
      halted = 1'b0;
      case (state_r)
         ST_RUN:    run_s  = 1'b1;
         ST_DRAIN:  run_s  = 1'b0;
         ST_HALTED: halted = 1'b1;
         default:   run_s  = 1'b0;
      endcase
   end

   // Live flags: a younger pipe write kills matching entries, a pop frees its slot, a push is always live
   always_comb begin
      live_nxt_s = live_r;
      for (int i = 0; i < DEPTH; i++) begin
         live_nxt_s[i] = (live_r[i]
                          & ~(pipe_wr_s && (rd_mem_r[i] == pipe_rd))
                          & ~(pop_s && (rd_ptr_r == PW'(i))))
                         | (push_s && (wr_ptr_r == PW'(i)));
      end
   end

   // FIFO control state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live_r   <= {DEPTH{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         live_r <= live_nxt_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO payload storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         rd_mem_r[wr_ptr_r]   <= lu_rd;
         data_mem_r[wr_ptr_r] <= lu_data;
      end
   end

   // Registered write port; rd/wdata hold when nothing is written
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_rd    <= RD_ZERO;
         rf_wdata <= {`XLEN{1'b0}};
      end else if (pipe_wr_s) begin
         rf_we    <= 1'b1;
         rf_rd    <= pipe_rd;
         rf_wdata <= pipe_data;
      end else if (pop_s && live_r[rd_ptr_r]) begin
         rf_we    <= 1'b1;
         rf_rd    <= rd_mem_r[rd_ptr_r];
         rf_wdata <= data_mem_r[rd_ptr_r];
      end else begin
         rf_we    <= 1'b0;
      end
   end

   // RAW hazard against live parked results or a result arriving this cycle
   always_comb begin
      query_stall = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live_r[i] && (query_rs1 != RD_ZERO) && (rd_mem_r[i] == query_rs1)) begin
            query_stall = 1'b1;
         end else if (live_r[i] && (query_rs2 != RD_ZERO) && (rd_mem_r[i] == query_rs2)) begin
            query_stall = 1'b1;
         end else begin
            query_stall = query_stall;
         end
      end
      if (lu_xfer_s && (query_rs1 != RD_ZERO) && (lu_rd == query_rs1)) begin
         query_stall = 1'b1;
      end else if (lu_xfer_s && (query_rs2 != RD_ZERO) && (lu_rd == query_rs2)) begin
         query_stall = 1'b1;
      end else begin
         query_stall = query_stall;
      end
   end

`ifdef WB_ARB_STATS_EN
   // Count cycles where a pipe write holds back a parked result, saturating
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_count <= 32'd0;
      end else if (!fifo_empty_s && pipe_wr_s && (conflict_count != 32'hFFFF_FFFF)) begin
         conflict_count <= conflict_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected writes (with cycle stamps) go into a scoreboard queue
// that a negedge monitor drains; side outputs are checked at fixed cycles.
`ifndef XLEN
`define XLEN 32
`endif

module tb_wb_port_arbiter;

   logic              clk = 1'b0;
   logic              rst;
   logic              pipe_valid;
   logic [4:0]        pipe_rd;
   logic [`XLEN-1:0]  pipe_data;
   logic              lu_valid;
   logic [4:0]        lu_rd;
   logic [`XLEN-1:0]  lu_data;
   logic              lu_ready;
   logic [4:0]        query_rs1;
   logic [4:0]        query_rs2;
   logic              query_stall;
   logic              halt_req;
   logic              halted;
   logic              rf_we;
   logic [4:0]        rf_rd;
   logic [`XLEN-1:0]  rf_wdata;
`ifdef WB_ARB_STATS_EN
   logic [31:0]       conflict_count;
`endif

   wb_port_arbiter #(.DEPTH(2), .REG_BITS(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .pipe_valid  (pipe_valid),
      .pipe_rd     (pipe_rd),
      .pipe_data   (pipe_data),
      .lu_valid    (lu_valid),
      .lu_rd       (lu_rd),
      .lu_data     (lu_data),
      .lu_ready    (lu_ready),
      .query_rs1   (query_rs1),
      .query_rs2   (query_rs2),
      .query_stall (query_stall),
      .halt_req    (halt_req),
      .halted      (halted),
      .rf_we       (rf_we),
      .rf_rd       (rf_rd),
      .rf_wdata    (rf_wdata)
`ifdef WB_ARB_STATS_EN
      ,
      .conflict_count (conflict_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int               cyc;
      logic [4:0]       rd;
      logic [`XLEN-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, req);
      end
   endtask

   task automatic expw(input int c, input logic [4:0] rd, input logic [`XLEN-1:0] data);
      exp_t e;
      e.cyc = c;
      e.rd = rd;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic set_in(input logic pv, input logic [4:0] prd, input logic [`XLEN-1:0] pd,
                         input logic lv, input logic [4:0] lrd, input logic [`XLEN-1:0] ld);
      pipe_valid = pv;
      pipe_rd    = prd;
      pipe_data  = pd;
      lu_valid   = lv;
      lu_rd      = lrd;
      lu_data    = ld;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every write must match the head expectation in cycle, rd and data
   always @(negedge clk) begin
      exp_t e;
      if (!rst && rf_we) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_write cyc=%0d got rd=%0d data=%h expected no write", cyc, rf_rd, rf_wdata);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.rd !== rf_rd || e.data !== rf_wdata) begin
               errors++;
               $display("FAIL write cyc=%0d got rd=%0d data=%h expected cyc=%0d rd=%0d data=%h",
                        cyc, rf_rd, rf_wdata, e.cyc, e.rd, e.data);
            end
         end
      end else if (!rst && exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
         checks++;
         errors++;
         e = exp_q.pop_front();
         $display("FAIL missing_write cyc=%0d got no write expected rd=%0d data=%h", cyc, e.rd, e.data);
      end
   end

   initial begin
      int c;
      rst = 1'b1;
      halt_req = 1'b0;
      query_rs1 = 5'd0;
      query_rs2 = 5'd0;
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      repeat (2) @(posedge clk);
      #2;
      chk("reset_rf_we", 32'(rf_we), 32'd0);
      chk("reset_rf_rd", 32'(rf_rd), 32'd0);
      chk("reset_rf_wdata", rf_wdata, 32'd0);
      chk("reset_halted", 32'(halted), 32'd0);
      chk("reset_lu_ready", 32'(lu_ready), 32'd1);
      tick();
      rst = 1'b0;
      #1;
      chk("post_reset_lu_ready", 32'(lu_ready), 32'd1);

      // Pipe only, then a pipe write to x0
      tick(); c = cyc;
      set_in(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
      expw(c + 1, 5'd3, 32'hDEADBEEF);
      tick();
      set_in(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1 chk("pipe_rd0_no_we", 32'(rf_we), 32'd0);
      tick();

      // Contention: rd 5 parked behind three pipe writes
      tick(); c = cyc;
      set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11);
      query_rs1 = 5'd5;
      #1 chk("stall_same_cycle_xfer", 32'(query_stall), 32'd1);
      chk("lu_ready_empty", 32'(lu_ready), 32'd1);
      tick();
      set_in(1'b1, 5'd6, 32'h61, 1'b0, 5'd0, 32'd0);
      expw(c + 2, 5'd6, 32'h61);
      #1 chk("stall_live_entry", 32'(query_stall), 32'd1);
      tick();
      set_in(1'b1, 5'd6, 32'h62, 1'b0, 5'd0, 32'd0);
      expw(c + 3, 5'd6, 32'h62);
      tick();
      set_in(1'b1, 5'd6, 32'h63, 1'b0, 5'd0, 32'd0);
      expw(c + 4, 5'd6, 32'h63);
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      query_rs1 = 5'd0;
      expw(c + 5, 5'd5, 32'h11);
      tick();
`ifdef WB_ARB_STATS_EN
      chk("conflict_count", conflict_count, 32'd3);
`endif
      tick();

      // Full FIFO and backpressure, then in-order retirement
      tick(); c = cyc;
      set_in(1'b1, 5'd10, 32'hA0, 1'b1, 5'd7, 32'h77);
      expw(c + 1, 5'd10, 32'hA0);
      tick();
      set_in(1'b1, 5'd10, 32'hA1, 1'b1, 5'd8, 32'h88);
      expw(c + 2, 5'd10, 32'hA1);
      tick();
      set_in(1'b1, 5'd10, 32'hA2, 1'b1, 5'd11, 32'hBAD);
      expw(c + 3, 5'd10, 32'hA2);
      #1 chk("full_lu_ready_0", 32'(lu_ready), 32'd0);
      tick();
      set_in(1'b1, 5'd10, 32'hA3, 1'b1, 5'd11, 32'hBAD);
      expw(c + 4, 5'd10, 32'hA3);
      #1 chk("full_lu_ready_0b", 32'(lu_ready), 32'd0);
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      expw(c + 5, 5'd7, 32'h77);
      #1 chk("pop_cycle_lu_ready_0", 32'(lu_ready), 32'd0);
      tick();
      expw(c + 6, 5'd8, 32'h88);
      #1 chk("after_pop_lu_ready_1", 32'(lu_ready), 32'd1);
      tick();
      tick();

      // WAW kill, then same-cycle younger lu result, and x0 pipe write not blocking
      tick(); c = cyc;
      set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hAA);
      tick();
      set_in(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'd0);
      expw(c + 2, 5'd9, 32'hBB);
      query_rs1 = 5'd9;
      #1 chk("waw_stall_before_kill", 32'(query_stall), 32'd1);
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1 chk("waw_stall_after_kill", 32'(query_stall), 32'd0);
      tick();
      query_rs1 = 5'd0;
      set_in(1'b1, 5'd13, 32'hC1, 1'b1, 5'd13, 32'hD1);
      expw(c + 4, 5'd13, 32'hC1);
      tick();
      set_in(1'b1, 5'd0, 32'hEE, 1'b0, 5'd0, 32'd0);
      expw(c + 5, 5'd13, 32'hD1);
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      tick();

      // RAW on rs2, and an lu result to x0 is dropped
      tick(); c = cyc;
      set_in(1'b1, 5'd14, 32'h14, 1'b1, 5'd12, 32'h12);
      expw(c + 1, 5'd14, 32'h14);
      tick();
      set_in(1'b1, 5'd14, 32'h15, 1'b0, 5'd0, 32'd0);
      expw(c + 2, 5'd14, 32'h15);
      query_rs2 = 5'd12;
      #1 chk("raw_rs2_stall", 32'(query_stall), 32'd1);
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      query_rs2 = 5'd0;
      expw(c + 3, 5'd12, 32'h12);
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99);
      #1 chk("rd0_no_stall", 32'(query_stall), 32'd0);
      chk("rd0_lu_ready", 32'(lu_ready), 32'd1);
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      tick();

      // Halt with two entries pending
      tick(); c = cyc;
      set_in(1'b1, 5'd15, 32'hF0, 1'b1, 5'd16, 32'h16);
      expw(c + 1, 5'd15, 32'hF0);
      tick();
      set_in(1'b1, 5'd15, 32'hF1, 1'b1, 5'd17, 32'h17);
      expw(c + 2, 5'd15, 32'hF1);
      #1 chk("pre_halt_lu_ready", 32'(lu_ready), 32'd1);
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      halt_req = 1'b1;
      expw(c + 3, 5'd16, 32'h16);
      #1 chk("halt_lu_ready_0", 32'(lu_ready), 32'd0);
      tick();
      halt_req = 1'b0;
      expw(c + 4, 5'd17, 32'h17);
      #1 chk("drain_lu_ready_0", 32'(lu_ready), 32'd0);
      chk("drain_halted_0", 32'(halted), 32'd0);
      tick();
      #1 chk("drain_exit_halted_0", 32'(halted), 32'd0);
      tick();
      #1 chk("halted_1", 32'(halted), 32'd1);
      chk("halted_lu_ready_0", 32'(lu_ready), 32'd0);
      tick();
      halt_req = 1'b1;
      #1 chk("halted_holds", 32'(halted), 32'd1);
      tick();
      halt_req = 1'b0;
      rst = 1'b1;
      #1 chk("reset_from_halted", 32'(halted), 32'd0);
      tick();
      rst = 1'b0;

      // Reset in the middle of a drain discards the FIFO and the in-flight write
      tick(); c = cyc;
      set_in(1'b1, 5'd18, 32'h18, 1'b1, 5'd19, 32'h19);
      expw(c + 1, 5'd18, 32'h18);
      tick();
      set_in(1'b1, 5'd18, 32'h1A, 1'b1, 5'd20, 32'h20);
      halt_req = 1'b1;
      expw(c + 2, 5'd18, 32'h1A);
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      halt_req = 1'b0;
      tick();
      chk("drain_pop_we", 32'(rf_we), 32'd1);
      chk("drain_pop_rd", 32'(rf_rd), 32'd19);
      rst = 1'b1;
      query_rs1 = 5'd20;
      #1 chk("midrst_rf_we", 32'(rf_we), 32'd0);
      chk("midrst_rf_rd", 32'(rf_rd), 32'd0);
      chk("midrst_rf_wdata", rf_wdata, 32'd0);
      chk("midrst_halted", 32'(halted), 32'd0);
      chk("midrst_lu_ready", 32'(lu_ready), 32'd1);
      chk("midrst_stall", 32'(query_stall), 32'd0);
      tick();
      rst = 1'b0;
      query_rs1 = 5'd0;
      tick();
      tick();

      // Minimum halt latency from idle
      tick(); c = cyc;
      halt_req = 1'b1;
      #1 chk("min_halt_lu_ready_1", 32'(lu_ready), 32'd1);
      tick();
      halt_req = 1'b0;
      #1 chk("min_halt_lu_ready_0", 32'(lu_ready), 32'd0);
      chk("min_halt_halted_0", 32'(halted), 32'd0);
      tick();
      #1 chk("min_halt_halted_1", 32'(halted), 32'd1);

      repeat (3) tick();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
